// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - shared parameters, state encodings and register map for the PLIC core
package plic_pkg;

  localparam int N_INT_SRC_DEF = 32;
  localparam int PRIO_W_DEF    = 3;

  // Source ID width; ID 0 is reserved, so at least two IDs always exist.
  function automatic int id_width(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

  localparam int ID_W_DEF = id_width(N_INT_SRC_DEF);

  // Register map of the surrounding register file.
  localparam logic [31:0] PLIC_BASE         = 32'h5000_0000;
  localparam logic [31:0] REG_PRIORITY_OFS  = 32'h0000_0000;
  localparam logic [31:0] REG_PENDING_OFS   = 32'h0000_1000;
  localparam logic [31:0] REG_ENABLE_OFS    = 32'h0000_2000;
  localparam logic [31:0] REG_THRESHOLD_OFS = 32'h0020_0000;
  localparam logic [31:0] REG_CLAIM_OFS     = 32'h0020_0004;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_ACK   = 2'd2
  } claim_state_t;

  typedef enum logic {
    GW_IDLE     = 1'b0,
    GW_INFLIGHT = 1'b1
  } gw_state_t;

endpackage

// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - per-source level gateway: latches one request until claimed and completed
module plic_gateway
  import plic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  gw_state_t state_q, state_d;
  logic      pending_d;

  // Next state: accept a request only when idle; completion is honoured once the claim has cleared pending
  always_comb begin
    state_d   = state_q;
    pending_d = pending;
    unique case (state_q)
      GW_IDLE: begin
        if (irq) begin
          state_d   = GW_INFLIGHT;
          pending_d = 1'b1;
        end
      end
      GW_INFLIGHT: begin
        if (claim) begin
          pending_d = 1'b0;
        end else if (complete && !pending) begin
          state_d = GW_IDLE;
        end
      end
      default: state_d = GW_IDLE;
    endcase
  end

  // State and pending registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GW_IDLE;
      pending <= 1'b0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
    end
  end

endmodule

// File: rtl/plic_claim_arbiter.sv
// rtl/plic_claim_arbiter.sv - single-context PLIC core: gateways, sequential priority sweep, claim/complete
module plic_claim_arbiter
  import plic_pkg::*;
#(
  parameter int N_INT_SRC = N_INT_SRC_DEF,
  parameter int PRIO_W    = PRIO_W_DEF,
  parameter int ID_W      = id_width(N_INT_SRC)
) (
  input  logic                        CLK,
  input  logic                        RST_X,
  input  logic [N_INT_SRC-1:0]        w_irq_src,
  input  logic [N_INT_SRC*PRIO_W-1:0] w_priority,
  input  logic [N_INT_SRC-1:0]        w_enable,
  input  logic [PRIO_W-1:0]           w_threshold,
  input  logic                        w_claim_req,
  output logic                        w_claim_ack,
  output logic [ID_W-1:0]             w_claim_id,
  input  logic                        w_complete_req,
  input  logic [ID_W-1:0]             w_complete_id,
  output logic [N_INT_SRC-1:0]        w_pending,
  output logic                        w_eip
);

  localparam logic [ID_W-1:0] FIRST_IDX = ID_W'(1);
  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(N_INT_SRC - 1);

  claim_state_t      state_q, state_d;
  logic [ID_W-1:0]   idx_q;
  logic [ID_W-1:0]   best_id_q, result_id_q, claim_id_q;
  logic [PRIO_W-1:0] best_prio_q, result_prio_q;
  logic [PRIO_W-1:0] prio_arr [N_INT_SRC];
  logic [PRIO_W-1:0] cur_prio, cand_prio;
  logic [ID_W-1:0]   cand_id;
  logic              cur_elig, last_slot;
  logic              sweep_restart, result_clear, id_capture;
  logic              eip_q;
  logic              unused_irq0;

  // ID 0 is reserved: it never has a gateway and never pends.
  assign unused_irq0  = w_irq_src[0];
  assign w_pending[0] = 1'b0;

  for (genvar i = 1; i < N_INT_SRC; i++) begin : g_gw
    plic_gateway u_gw (
      .clk      (CLK),
      .rst      (RST_X),
      .irq      (w_irq_src[i]),
      .claim    (w_claim_ack && (claim_id_q == ID_W'(i))),
      .complete (w_complete_req && (w_complete_id == ID_W'(i))),
      .pending  (w_pending[i])
    );
  end

  // Unpack the flattened priority bus so the sweep can index it by source ID
  always_comb begin
    for (int i = 0; i < N_INT_SRC; i++) begin
      prio_arr[i] = w_priority[i*PRIO_W +: PRIO_W];
    end
  end

  // Evaluate the slot under the sweep index; strict compare keeps the lowest ID on ties
  always_comb begin
    cur_prio  = prio_arr[idx_q];
    cur_elig  = w_pending[idx_q] & w_enable[idx_q] & (cur_prio != '0);
    last_slot = (idx_q == LAST_IDX);
    cand_id   = best_id_q;
    cand_prio = best_prio_q;
    if (cur_elig && (cur_prio > best_prio_q)) begin
      cand_id   = idx_q;
      cand_prio = cur_prio;
    end
  end

  // Claim FSM next state and control strobes
  always_comb begin
    state_d       = state_q;
    sweep_restart = 1'b0;
    result_clear  = 1'b0;
    id_capture    = 1'b0;
    w_claim_ack   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_claim_req) begin
          sweep_restart = 1'b1;
          state_d       = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (last_slot) begin
          id_capture = 1'b1;
          state_d    = S_ACK;
        end
      end
      S_ACK: begin
        w_claim_ack   = 1'b1;
        sweep_restart = 1'b1;
        result_clear  = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Claim FSM state register
  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Free-running sweep: advance one slot per cycle, publish the winner on wrap
  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      idx_q         <= FIRST_IDX;
      best_id_q     <= '0;
      best_prio_q   <= '0;
      result_id_q   <= '0;
      result_prio_q <= '0;
    end else begin
      if (sweep_restart) begin
        idx_q       <= FIRST_IDX;
        best_id_q   <= '0;
        best_prio_q <= '0;
      end else if (last_slot) begin
        idx_q         <= FIRST_IDX;
        best_id_q     <= '0;
        best_prio_q   <= '0;
        result_id_q   <= cand_id;
        result_prio_q <= cand_prio;
      end else begin
        idx_q       <= idx_q + ID_W'(1);
        best_id_q   <= cand_id;
        best_prio_q <= cand_prio;
      end
      if (result_clear) begin
        result_id_q   <= '0;
        result_prio_q <= '0;
      end
    end
  end

  // Claimed ID is captured as the claim sweep finishes and held until the next claim
  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      claim_id_q <= '0;
    end else if (id_capture) begin
      claim_id_q <= cand_id;
    end
  end

  // Interrupt line: the published winner must beat the threshold
  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      eip_q <= 1'b0;
    end else begin
      eip_q <= (result_prio_q > w_threshold) && (result_id_q != '0);
    end
  end

  assign w_claim_id = claim_id_q;
  assign w_eip      = eip_q;

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// tb/tb_plic_claim_arbiter.sv - directed self-checking bench for plic_claim_arbiter
module tb_plic_claim_arbiter;

  localparam int N  = 32;
  localparam int PW = 3;
  localparam int IW = 5;

  logic          CLK;
  logic          RST_X;
  logic [N-1:0]  w_irq_src;
  logic [N*PW-1:0] w_priority;
  logic [N-1:0]  w_enable;
  logic [PW-1:0] w_threshold;
  logic          w_claim_req;
  logic          w_claim_ack;
  logic [IW-1:0] w_claim_id;
  logic          w_complete_req;
  logic [IW-1:0] w_complete_id;
  logic [N-1:0]  w_pending;
  logic          w_eip;

  int checks = 0;
  int errors = 0;

  plic_claim_arbiter dut (
    .CLK            (CLK),
    .RST_X          (RST_X),
    .w_irq_src      (w_irq_src),
    .w_priority     (w_priority),
    .w_enable       (w_enable),
    .w_threshold    (w_threshold),
    .w_claim_req    (w_claim_req),
    .w_claim_ack    (w_claim_ack),
    .w_claim_id     (w_claim_id),
    .w_complete_req (w_complete_req),
    .w_complete_id  (w_complete_id),
    .w_pending      (w_pending),
    .w_eip          (w_eip)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_prio(input int src, input int p);
    logic [PW-1:0] pv;
    pv = PW'(p);
    w_priority[src*PW +: PW] = pv;
  endtask

  task automatic pulse_irq(input logic [N-1:0] mask);
    w_irq_src = mask;
    tick();
    w_irq_src = '0;
  endtask

  task automatic complete(input int id);
    w_complete_req = 1'b1;
    w_complete_id  = IW'(id);
    tick();
    w_complete_req = 1'b0;
    w_complete_id  = '0;
  endtask

  // Issue a claim and expect exactly one ack at t+32 carrying exp_id.
  task automatic do_claim(input string tag, input int exp_id, input bit mid_req,
                          input bit cmp_at_ack, input int cmp_id);
    int lat;
    int extra;
    w_claim_req = 1'b1;
    tick();
    w_claim_req = 1'b0;
    lat = 1;
    while (!w_claim_ack && lat < 40) begin
      w_claim_req = (mid_req && lat == 10);
      tick();
      lat++;
    end
    w_claim_req = 1'b0;
    chk({tag, "_ack_seen"}, 32'(w_claim_ack), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd32);
    chk({tag, "_id"}, 32'(w_claim_id), 32'(exp_id));
    if (cmp_at_ack) begin
      w_complete_req = 1'b1;
      w_complete_id  = IW'(cmp_id);
    end
    tick();
    w_complete_req = 1'b0;
    w_complete_id  = '0;
    chk({tag, "_ack_one_cycle"}, 32'(w_claim_ack), 32'd0);
    chk({tag, "_id_hold"}, 32'(w_claim_id), 32'(exp_id));
    if (mid_req) begin
      extra = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (w_claim_ack) extra++;
      end
      chk({tag, "_extra_acks"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    bit seen;

    RST_X          = 1'b1;
    w_irq_src      = '0;
    w_priority     = '0;
    w_enable       = '0;
    w_threshold    = '0;
    w_claim_req    = 1'b0;
    w_complete_req = 1'b0;
    w_complete_id  = '0;
    tick();
    tick();
    tick();
    RST_X = 1'b0;
    tick();

    chk("rst_pending", w_pending, 32'h0);
    chk("rst_eip", 32'(w_eip), 32'd0);
    chk("rst_ack", 32'(w_claim_ack), 32'd0);
    chk("rst_id", 32'(w_claim_id), 32'd0);

    // Reset in the middle of a claim sweep
    set_prio(5, 3);
    w_enable[5] = 1'b1;
    pulse_irq(32'h0000_0020);
    chk("pre_rst_pend5", w_pending, 32'h0000_0020);
    w_claim_req = 1'b1;
    tick();
    w_claim_req = 1'b0;
    tick();
    tick();
    tick();
    RST_X = 1'b1;
    #1;
    chk("midrst_pending", w_pending, 32'h0);
    chk("midrst_eip", 32'(w_eip), 32'd0);
    chk("midrst_ack", 32'(w_claim_ack), 32'd0);
    tick();
    tick();
    RST_X = 1'b0;
    tick();
    do_claim("claim_after_rst", 0, 1'b0, 1'b0, 0);

    // Tie between 5 and 9 at priority 3 above threshold 2
    set_prio(9, 3);
    w_enable[9] = 1'b1;
    w_threshold = 3'd2;
    pulse_irq(32'h0000_0220);
    seen = 1'b0;
    for (int k = 0; k < 66 && !seen; k++) begin
      tick();
      if (w_eip) seen = 1'b1;
    end
    chk("tie_eip_rises", 32'(seen), 32'd1);
    do_claim("tie_claim", 5, 1'b0, 1'b0, 0);
    chk("tie_pending_after", w_pending, 32'h0000_0200);
    complete(5);
    do_claim("second_claim", 9, 1'b0, 1'b0, 0);
    chk("second_pending_after", w_pending, 32'h0);
    complete(9);

    // Priority equal to threshold never raises eip, but can still be claimed
    set_prio(3, 1);
    w_enable[3] = 1'b1;
    w_threshold = 3'd1;
    pulse_irq(32'h0000_0008);
    seen = 1'b0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (w_eip) seen = 1'b1;
    end
    chk("thr_eip_low", 32'(seen), 32'd0);
    do_claim("thr_claim", 3, 1'b0, 1'b0, 0);
    complete(3);

    // Completes that must be ignored: pending still set, and reserved ID 0
    set_prio(7, 2);
    w_enable[7] = 1'b1;
    pulse_irq(32'h0000_0080);
    chk("g7_pending", w_pending, 32'h0000_0080);
    complete(7);
    complete(0);
    chk("g7_early_complete_ignored", w_pending, 32'h0000_0080);
    do_claim("g7_claim", 7, 1'b0, 1'b0, 0);
    chk("g7_cleared", w_pending, 32'h0);

    // Level held high: gateway stays in flight until completed
    w_irq_src[7] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("g7_held_inflight", w_pending, 32'h0);
    w_complete_req = 1'b1;
    w_complete_id  = IW'(7);
    tick();
    w_complete_req = 1'b0;
    chk("g7_idle_edge", w_pending, 32'h0);
    tick();
    chk("g7_repend", w_pending, 32'h0000_0080);

    // Complete on the ack cycle of the same ID is ignored
    do_claim("g7_claim_cmp", 7, 1'b0, 1'b1, 7);
    tick();
    tick();
    chk("g7_same_cycle_cmp_ignored", w_pending, 32'h0);
    w_irq_src[7] = 1'b0;
    complete(7);
    tick();
    chk("g7_final_idle", w_pending, 32'h0);

    // Disabled high-priority source loses; extra claim pulse mid-sweep is ignored
    w_enable = '0;
    w_enable[2] = 1'b1;
    set_prio(4, 7);
    set_prio(2, 1);
    pulse_irq(32'h0000_0014);
    do_claim("dis_claim", 2, 1'b1, 1'b0, 0);
    chk("dis_pending_after", w_pending, 32'h0000_0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plic_claim_arbiter.md
Name: plic_claim_arbiter

Overview:
- Single-context interrupt arbitration core behind the PLIC register file (base 0x5000_0000).
- Per-source gateways latch level requests into pending bits.
- A sequential sweep finds the highest-priority eligible source and drives the external-interrupt line.
- Serves the claim/complete handshake for the context's claim/complete register.

Parameters:
- N_INT_SRC, 32: number of source IDs including reserved ID 0. Must be ≥2.
- PRIO_W, 3: priority and threshold width.
- ID_W, $clog2(N_INT_SRC): source ID width.

Ports:
- CLK  in  1  system clock
- RST_X  in  1  reset, asynchronous, active-high (1 = reset)
- w_irq_src  in  N_INT_SRC  level interrupt requests; bit 0 ignored
- w_priority  in  N_INT_SRC*PRIO_W  flattened priorities, source i at [i*PRIO_W +: PRIO_W]
- w_enable  in  N_INT_SRC  context enable mask
- w_threshold  in  PRIO_W  context threshold
- w_claim_req  in  1  one-cycle pulse: claim register read
- w_claim_ack  out  1  one-cycle pulse: w_claim_id valid
- w_claim_id  out  ID_W  claimed ID; 0 = none
- w_complete_req  in  1  one-cycle pulse: complete register write
- w_complete_id  in  ID_W  ID being completed
- w_pending  out  N_INT_SRC  pending bits, for the pending register
- w_eip  out  1  external interrupt to the hart

Behaviour:
- Reset (async, any time):
  - All gateways go to IDLE; pending = 0.
  - Sweep index = 1; best = 0; result = 0.
  - FSM = S_IDLE; w_claim_ack = 0, w_claim_id = 0, w_eip = 0.
- Gateway, per source i ≥ 1 (two states):
  - IDLE and w_irq_src[i]=1: set pending[i], go to INFLIGHT.
  - INFLIGHT ignores w_irq_src.
  - Claim of i clears pending[i]; gateway stays INFLIGHT.
  - w_complete_req with w_complete_id==i, gateway INFLIGHT, pending[i]=0: go to IDLE.
  - Completes for other states, ID 0, or IDs ≥ N_INT_SRC are silently ignored.
  - Complete and a high irq in the same cycle: gateway reaches IDLE at that edge; the new pending bit sets one cycle later.
- Eligibility: pending[i] & w_enable[i] & (priority[i] != 0). Enable and priority are sampled when index i is scanned.
- Sweep (free-running):
  - Evaluates one source per cycle, index 1 to N_INT_SRC-1.
  - Best is replaced only on strictly greater priority, so the lowest ID wins ties.
  - After index N_INT_SRC-1 is evaluated: latch best into result {id, prio}, clear best, wrap index to 1.
  - A source that becomes pending after its slot was scanned is caught on the next sweep.
- w_eip: registered; equals (result.prio > w_threshold) & (result.id != 0).
- Claim FSM:
  - S_IDLE: on w_claim_req, restart the sweep (index = 1, best cleared), go to S_SWEEP.
  - S_SWEEP: when index N_INT_SRC-1 is evaluated, go to S_ACK.
  - S_ACK:
    - Assert w_claim_ack for one cycle; w_claim_id = best id (0 if none).
    - At the end of the cycle, clear pending[id] (if id != 0) and set result = 0.
    - Restart the sweep; go to S_IDLE.
  - Latency: claim_req at cycle t gives ack at cycle t+N_INT_SRC, fixed.
  - w_claim_req outside S_IDLE is ignored; the register file stalls the bus until ack.
  - w_claim_id holds its value after ack until the next ack.
- Threshold does not gate claims; it only gates w_eip.
- Concurrency:
  - w_complete_req is accepted in every FSM state.
  - Complete and claim acting on the same ID in the same cycle are independent: claim clears pending, and complete is ignored because pending was still 1 at that edge.

Decomposition:
- Package plic_pkg:
  - N_INT_SRC and PRIO_W defaults.
  - ID_W derivation.
  - Claim FSM state encoding (S_IDLE, S_SWEEP, S_ACK).
  - Gateway state encoding.
  - Register offsets: priority 0x0, pending 0x1000, enable 0x2000, threshold/claim 0x200000/0x200004.
- Sub-module plic_gateway: one instance per source via generate. Ports: irq, claim, complete, pending.

Test Plan:
- Reset mid-sweep (RST_X high 2 cycles during S_SWEEP) -> w_pending = 0, w_eip = 0, w_claim_ack = 0, FSM idle; a claim afterwards returns id 0.
- Src 5 prio 3, src 9 prio 3, both enabled, threshold 2 -> w_eip = 1 within 2*31 cycles; claim returns 5 at exactly t+32; pending[5] = 0, pending[9] = 1.
- Src 3 prio 1, threshold 1 -> w_eip stays 0; claim still returns 3.
- Src 7 level held high, claim then complete(7) -> pending[7] stays 0 until the complete, then re-sets 1 cycle after the complete.
- Complete(7) while pending[7] = 1 (unclaimed), and complete(0) -> ignored; gateway stays INFLIGHT, no state change.
- Src 4 disabled prio 7, src 2 enabled prio 1 -> claim returns 2; w_claim_req pulsed during S_SWEEP -> exactly one ack.
